// File: rtl/sevenseg_capture.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_capture
// Description : Receive side of a multiplexed seven-segment display bus.
//               Samples the active-low segment lines and the one-hot digit
//               select, waits for a stable run of identical samples, then
//               decodes the pattern back to a hex nibble for that digit and
//               flags blank or illegal patterns.
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   digit_sel,
    output logic [4*NUM_DIGITS-1:0] hex_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    update,
    output logic [2:0]              update_idx
);

    // Run length at which a pattern is considered settled.
    localparam logic [15:0] STABLE_RUN    = 16'(STABLE_CYCLES);
    // All segments dark (active-low bus).
    localparam logic [6:0]  BLANK_PATTERN = 7'h7F;

    // Previous-sample history and run tracking.
    logic [NUM_DIGITS-1:0] prev_sel;
    logic [6:0]            prev_seg;
    logic [15:0]           run;
    logic [15:0]           run_next;

    // Select qualification.
    logic [3:0]            sel_count;
    logic [2:0]            sel_idx;
    logic                  sel_ok;
    logic                  match;
    logic                  commit;

    // Pattern decode results.
    logic [3:0]            dec_value;
    logic                  dec_legal;
    logic                  dec_blank;

    // Count asserted select lines and encode the position of the active one.
    always_comb begin
        sel_count = '0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_sel[i]) begin
                sel_count = sel_count + 4'd1;
                sel_idx   = 3'(i);
            end
        end
        sel_ok = (sel_count == 4'd1);
    end

    // Map the active-low segment pattern back to its hex value.
    always_comb begin
        dec_value = 4'h0;
        dec_legal = 1'b1;
        dec_blank = (seg_in == BLANK_PATTERN);
        case (seg_in)
            7'h40:   dec_value = 4'h0;
            7'h79:   dec_value = 4'h1;
            7'h24:   dec_value = 4'h2;
            7'h30:   dec_value = 4'h3;
            7'h19:   dec_value = 4'h4;
            7'h12:   dec_value = 4'h5;
            7'h02:   dec_value = 4'h6;
            7'h78:   dec_value = 4'h7;
            7'h00:   dec_value = 4'h8;
            7'h10:   dec_value = 4'h9;
            7'h08:   dec_value = 4'hA;
            7'h03:   dec_value = 4'hB;
            7'h46:   dec_value = 4'hC;
            7'h21:   dec_value = 4'hD;
            7'h06:   dec_value = 4'hE;
            7'h0E:   dec_value = 4'hF;
            default: dec_legal = 1'b0;
        endcase
    end

    // Next run length; a commit fires only on the edge the run first reaches
    // the threshold, so a held pattern never re-commits.
    always_comb begin
        match = sel_ok && (digit_sel == prev_sel) && (seg_in == prev_seg)
                && (run != 16'd0);
        if (!sel_ok) begin
            run_next = 16'd0;
        end else if (match) begin
            run_next = (run >= STABLE_RUN) ? STABLE_RUN : run + 16'd1;
        end else begin
            run_next = 16'd1;
        end
        commit = (run_next == STABLE_RUN) && (run != STABLE_RUN);
    end

    // Sample history, run counter and the update pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            prev_sel   <= '0;
            prev_seg   <= BLANK_PATTERN;
            run        <= 16'd0;
            update     <= 1'b0;
            update_idx <= 3'd0;
        end else begin
            prev_sel <= digit_sel;
            prev_seg <= seg_in;
            run      <= run_next;
            update   <= commit;
            if (commit) begin
                update_idx <= sel_idx;
            end
        end
    end

    // Per-digit result registers; only the selected digit changes on commit.
    // Blank and illegal patterns leave the previous nibble in place.
    always_ff @(posedge clock) begin
        if (reset) begin
            hex_out     <= '0;
            digit_valid <= '0;
            digit_err   <= '0;
        end else if (commit) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (digit_sel[k]) begin
                    if (dec_legal) begin
                        hex_out[4*k +: 4] <= dec_value;
                        digit_valid[k]    <= 1'b1;
                        digit_err[k]      <= 1'b0;
                    end else begin
                        digit_valid[k]    <= 1'b0;
                        digit_err[k]      <= !dec_blank;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_sevenseg_capture
// Description : Self-checking bench for sevenseg_capture; two instances
//               (stable threshold 4 and 1) share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sevenseg_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  seg_in;
    logic [3:0]  digit_sel;

    logic [15:0] hex_a, hex_b;
    logic [3:0]  val_a, val_b, err_a, err_b;
    logic        upd_a, upd_b;
    logic [2:0]  idx_a, idx_b;

    int errors = 0;
    int checks = 0;

    sevenseg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut_s4 (
        .clock(clock), .reset(reset), .seg_in(seg_in), .digit_sel(digit_sel),
        .hex_out(hex_a), .digit_valid(val_a), .digit_err(err_a),
        .update(upd_a), .update_idx(idx_a)
    );

    sevenseg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(1)) dut_s1 (
        .clock(clock), .reset(reset), .seg_in(seg_in), .digit_sel(digit_sel),
        .hex_out(hex_b), .digit_valid(val_b), .digit_err(err_b),
        .update(upd_b), .update_idx(idx_b)
    );

    always #5 clock = ~clock;

    // Segment pattern for each hex value, indexed by value.
    logic [6:0] pats [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state, one copy per instance (0: threshold 4, 1: threshold 1).
    int          thr    [2] = '{4, 1};
    logic [3:0]  m_psel [2];
    logic [6:0]  m_pseg [2];
    int          m_streak [2];
    logic [3:0]  m_hex  [2][4];
    logic        m_val  [2][4];
    logic        m_err  [2][4];
    logic        m_upd  [2];
    logic [2:0]  m_idx  [2];

    typedef struct {
        logic [3:0]  sel;
        logic [6:0]  seg;
        int          n;
        logic        upd;
        logic [2:0]  idx;
        logic [15:0] hex;
        logic [3:0]  val;
        logic [3:0]  err;
    } vec_t;

    vec_t tbl [24];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Streak of identical single-digit samples, capped at the threshold;
    // a commit is the first time the capped streak reaches the threshold.
    task automatic model_step(input int m, input logic r, input logic [3:0] sel, input logic [6:0] seg);
        int old_len, new_len, k, found;
        if (r) begin
            m_psel[m] = '0; m_pseg[m] = 7'h7F; m_streak[m] = 0;
            m_upd[m] = 1'b0; m_idx[m] = '0;
            for (int d = 0; d < 4; d++) begin
                m_hex[m][d] = '0; m_val[m][d] = 1'b0; m_err[m][d] = 1'b0;
            end
            return;
        end
        old_len = m_streak[m];
        if ($countones(sel) != 1) new_len = 0;
        else if (sel == m_psel[m] && seg == m_pseg[m] && old_len != 0)
            new_len = (old_len + 1 > thr[m]) ? thr[m] : old_len + 1;
        else new_len = 1;
        m_upd[m] = (new_len == thr[m]) && (old_len != thr[m]);
        if (m_upd[m]) begin
            k = 0;
            for (int d = 0; d < 4; d++) if (sel[d]) k = d;
            m_idx[m] = 3'(k);
            found = -1;
            for (int v = 0; v < 16; v++) if (pats[v] == seg) found = v;
            if (found >= 0) begin
                m_hex[m][k] = 4'(found); m_val[m][k] = 1'b1; m_err[m][k] = 1'b0;
            end else begin
                m_val[m][k] = 1'b0; m_err[m][k] = (seg != 7'h7F);
            end
        end
        m_streak[m] = new_len;
        m_psel[m] = sel;
        m_pseg[m] = seg;
    endtask

    function automatic logic [15:0] exp_hex(input int m);
        logic [15:0] h;
        for (int d = 0; d < 4; d++) h[4*d +: 4] = m_hex[m][d];
        return h;
    endfunction

    function automatic logic [3:0] exp_val(input int m);
        logic [3:0] v;
        for (int d = 0; d < 4; d++) v[d] = m_val[m][d];
        return v;
    endfunction

    function automatic logic [3:0] exp_err(input int m);
        logic [3:0] v;
        for (int d = 0; d < 4; d++) v[d] = m_err[m][d];
        return v;
    endfunction

    task automatic compare_model();
        check("s4_hex", 32'(hex_a), 32'(exp_hex(0)));
        check("s4_valid", 32'(val_a), 32'(exp_val(0)));
        check("s4_err", 32'(err_a), 32'(exp_err(0)));
        check("s4_update", 32'(upd_a), 32'(m_upd[0]));
        check("s4_idx", 32'(idx_a), 32'(m_idx[0]));
        check("s1_hex", 32'(hex_b), 32'(exp_hex(1)));
        check("s1_valid", 32'(val_b), 32'(exp_val(1)));
        check("s1_err", 32'(err_b), 32'(exp_err(1)));
        check("s1_update", 32'(upd_b), 32'(m_upd[1]));
        check("s1_idx", 32'(idx_b), 32'(m_idx[1]));
    endtask

    // One clock edge with the given inputs, then compare against the model.
    task automatic step(input logic r, input logic [3:0] sel, input logic [6:0] seg);
        reset = r; digit_sel = sel; seg_in = seg;
        @(posedge clock);
        model_step(0, r, sel, seg);
        model_step(1, r, sel, seg);
        #1;
        compare_model();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_hex_s4"}, 32'(hex_a), 32'h0);
        check({tag, "_valid_s4"}, 32'(val_a), 32'h0);
        check({tag, "_err_s4"}, 32'(err_a), 32'h0);
        check({tag, "_update_s4"}, 32'(upd_a), 32'h0);
        check({tag, "_idx_s4"}, 32'(idx_a), 32'h0);
        check({tag, "_hex_s1"}, 32'(hex_b), 32'h0);
        check({tag, "_valid_s1"}, 32'(val_b), 32'h0);
        check({tag, "_update_s1"}, 32'(upd_b), 32'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Expected results for the threshold-4 instance; each row holds for all n edges.
        tbl[0]  = '{4'b0010, 7'h24, 3,  1'b0, 3'd0, 16'h0000, 4'b0000, 4'b0000};
        tbl[1]  = '{4'b0010, 7'h24, 1,  1'b1, 3'd1, 16'h0020, 4'b0010, 4'b0000};
        tbl[2]  = '{4'b0010, 7'h24, 2,  1'b0, 3'd1, 16'h0020, 4'b0010, 4'b0000};
        tbl[3]  = '{4'b0000, 7'h7F, 1,  1'b0, 3'd1, 16'h0020, 4'b0010, 4'b0000};
        tbl[4]  = '{4'b0100, 7'h19, 3,  1'b0, 3'd1, 16'h0020, 4'b0010, 4'b0000};
        tbl[5]  = '{4'b0100, 7'h00, 1,  1'b0, 3'd1, 16'h0020, 4'b0010, 4'b0000};
        tbl[6]  = '{4'b0100, 7'h19, 3,  1'b0, 3'd1, 16'h0020, 4'b0010, 4'b0000};
        tbl[7]  = '{4'b0100, 7'h19, 1,  1'b1, 3'd2, 16'h0420, 4'b0110, 4'b0000};
        tbl[8]  = '{4'b0000, 7'h7F, 1,  1'b0, 3'd2, 16'h0420, 4'b0110, 4'b0000};
        tbl[9]  = '{4'b0001, 7'h0E, 3,  1'b0, 3'd2, 16'h0420, 4'b0110, 4'b0000};
        tbl[10] = '{4'b0001, 7'h0E, 1,  1'b1, 3'd0, 16'h042F, 4'b0111, 4'b0000};
        tbl[11] = '{4'b0000, 7'h7F, 1,  1'b0, 3'd0, 16'h042F, 4'b0111, 4'b0000};
        tbl[12] = '{4'b0001, 7'h7F, 3,  1'b0, 3'd0, 16'h042F, 4'b0111, 4'b0000};
        tbl[13] = '{4'b0001, 7'h7F, 1,  1'b1, 3'd0, 16'h042F, 4'b0110, 4'b0000};
        tbl[14] = '{4'b0000, 7'h7F, 1,  1'b0, 3'd0, 16'h042F, 4'b0110, 4'b0000};
        tbl[15] = '{4'b0001, 7'h55, 3,  1'b0, 3'd0, 16'h042F, 4'b0110, 4'b0000};
        tbl[16] = '{4'b0001, 7'h55, 1,  1'b1, 3'd0, 16'h042F, 4'b0110, 4'b0001};
        tbl[17] = '{4'b0110, 7'h55, 10, 1'b0, 3'd0, 16'h042F, 4'b0110, 4'b0001};
        tbl[18] = '{4'b0000, 7'h55, 10, 1'b0, 3'd0, 16'h042F, 4'b0110, 4'b0001};
        tbl[19] = '{4'b1000, 7'h21, 3,  1'b0, 3'd0, 16'h042F, 4'b0110, 4'b0001};
        tbl[20] = '{4'b1000, 7'h21, 1,  1'b1, 3'd3, 16'hD42F, 4'b1110, 4'b0001};
        tbl[21] = '{4'b0100, 7'h21, 3,  1'b0, 3'd3, 16'hD42F, 4'b1110, 4'b0001};
        tbl[22] = '{4'b0100, 7'h21, 1,  1'b1, 3'd2, 16'hDD2F, 4'b1110, 4'b0001};
        tbl[23] = '{4'b0000, 7'h7F, 1,  1'b0, 3'd2, 16'hDD2F, 4'b1110, 4'b0001};

        reset = 1'b1; digit_sel = '0; seg_in = 7'h7F;

        // Reset for two cycles, then idle with no digit selected.
        step(1'b1, 4'b0000, 7'h7F);
        step(1'b1, 4'b0000, 7'h7F);
        check_cleared("reset");
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 4'b0000, 7'h7F);
            check_cleared("idle");
        end

        // Directed vectors: basic commit, glitch, blank/illegal, select faults, digit switch.
        for (int i = 0; i < 24; i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                step(1'b0, tbl[i].sel, tbl[i].seg);
                check($sformatf("tbl%0d_update", i), 32'(upd_a), 32'(tbl[i].upd));
                check($sformatf("tbl%0d_idx", i), 32'(idx_a), 32'(tbl[i].idx));
                check($sformatf("tbl%0d_hex", i), 32'(hex_a), 32'(tbl[i].hex));
                check($sformatf("tbl%0d_valid", i), 32'(val_a), 32'(tbl[i].val));
                check($sformatf("tbl%0d_err", i), 32'(err_a), 32'(tbl[i].err));
            end
        end

        // Reset in the middle of a run: partial run discarded, state cleared.
        step(1'b0, 4'b0001, 7'h40);
        step(1'b0, 4'b0001, 7'h40);
        step(1'b1, 4'b0001, 7'h40);
        check_cleared("midreset");
        step(1'b0, 4'b0001, 7'h40);
        step(1'b0, 4'b0001, 7'h40);
        check("midreset_no_commit_s4", 32'(upd_a), 32'h0);
        check("midreset_valid_s4", 32'(val_a), 32'h0);

        // Sweep all sixteen patterns round-robin across the four digits.
        for (int v = 0; v < 16; v++) begin
            step(1'b0, 4'b0000, 7'h7F);
            for (int j = 0; j < 5; j++) step(1'b0, 4'(1 << (v % 4)), pats[v]);
        end
        check("sweep_hex_s4", 32'(hex_a), 32'hFEDC);
        check("sweep_valid_s4", 32'(val_a), 32'hF);
        check("sweep_err_s4", 32'(err_a), 32'h0);
        check("sweep_hex_s1", 32'(hex_b), 32'hFEDC);
        check("sweep_valid_s1", 32'(val_b), 32'hF);
        check("sweep_err_s1", 32'(err_b), 32'h0);

        // Randomised held patterns with occasional select faults and resets.
        for (int t = 0; t < 300; t++) begin
            logic [3:0] sel;
            logic [6:0] seg;
            int         n;
            int         pick;
            logic       rst_now;
            pick = int'($urandom_range(0, 5));
            if (pick == 0)      sel = 4'b0000;
            else if (pick == 1) sel = 4'($urandom);
            else                sel = 4'(4'b0001 << $urandom_range(0, 3));
            pick = int'($urandom_range(0, 9));
            if (pick < 6)       seg = pats[$urandom_range(0, 15)];
            else if (pick == 6) seg = 7'h7F;
            else                seg = 7'($urandom);
            n = int'($urandom_range(1, 6));
            rst_now = ($urandom_range(0, 49) == 0);
            for (int j = 0; j < n; j++) step(rst_now && (j == 0), sel, seg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
